// File: rtl/sd_core_pkg.sv
// Register map, status bits, command codes and sequencer state encoding
// for the SD-card Avalon-MM slave core.
package sd_core_pkg;

  localparam logic [7:0] ADDR_CMD_ARG = 8'd139;
  localparam logic [7:0] ADDR_CMD     = 8'd140;
  localparam logic [7:0] ADDR_ASR     = 8'd141;

  localparam int ASR_VALID   = 0;
  localparam int ASR_PRESENT = 1;
  localparam int ASR_BUSY    = 2;
  localparam int ASR_TIMEOUT = 4;
  localparam int ASR_CRC     = 5;

  localparam logic [31:0] CMD_READ_BLOCK = 32'd17;

  localparam logic [1:0] ERR_OK           = 2'd0;
  localparam logic [1:0] ERR_NO_CARD      = 2'd1;
  localparam logic [1:0] ERR_CORE         = 2'd2;
  localparam logic [1:0] ERR_POLL_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_ARG  = 3'd2,
    S_CMD  = 3'd3,
    S_POLL = 3'd4,
    S_BUF  = 3'd5,
    S_OUT  = 3'd6,
    S_DONE = 3'd7
  } seq_state_t;

  // SDSC cards take a byte address, SDHC cards take the block number directly.
  function automatic logic [31:0] cmd_arg(input logic [31:0] lba, input logic byte_mode);
    return byte_mode ? {lba[22:0], 9'd0} : lba;
  endfunction

endpackage

// File: rtl/sd_avm_single_access.sv
// Single non-pipelined Avalon-MM access: strobes are held from i_start until the
// cycle the slave drops waitrequest; o_done/o_readdata are valid in that cycle.
module sd_avm_single_access (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [7:0]  i_address,
  input  logic [31:0] i_writedata,
  output logic        o_done,
  output logic [31:0] o_readdata,
  output logic        o_avm_chip_select,
  output logic [7:0]  o_avm_address,
  output logic        o_avm_read,
  output logic        o_avm_write,
  output logic [3:0]  o_avm_byteenable,
  output logic [31:0] o_avm_writedata,
  input  logic [31:0] i_avm_readdata,
  input  logic        i_avm_waitrequest
);

  logic        r_active;
  logic        r_write;
  logic [7:0]  r_address;
  logic [31:0] r_writedata;
  logic        w_done;

  assign w_done = r_active & ~i_avm_waitrequest;

  // A new start in the completing cycle keeps the bus busy for a back-to-back access.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_active    <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= 8'd0;
      r_writedata <= 32'd0;
    end else if (i_start) begin
      r_active    <= 1'b1;
      r_write     <= i_write;
      r_address   <= i_address;
      r_writedata <= i_writedata;
    end else if (w_done) begin
      r_active    <= 1'b0;
    end else begin
      r_active    <= r_active;
    end
  end

  assign o_done            = w_done;
  assign o_readdata        = i_avm_readdata;
  assign o_avm_chip_select = r_active;
  assign o_avm_address     = r_address;
  assign o_avm_read        = r_active & ~r_write;
  assign o_avm_write       = r_active & r_write;
  assign o_avm_byteenable  = r_active ? 4'hF : 4'h0;
  assign o_avm_writedata   = r_writedata;

endmodule

// File: rtl/sd_sector_read_sequencer.sv
// Reads one 512-byte sector per request from the SD core: status check, argument and
// READ_BLOCK command writes, busy poll, then 128 buffer reads streamed out in order.
module sd_sector_read_sequencer
  import sd_core_pkg::*;
#(
  parameter int POLL_TIMEOUT    = 1000000,
  parameter bit BYTE_ADDRESSING = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_lba,
  output logic        o_req_ready,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  output logic        o_data_last,
  input  logic        i_data_ready,
  output logic        o_done,
  output logic [1:0]  o_error,
  output logic        o_avm_chip_select,
  output logic [7:0]  o_avm_address,
  output logic        o_avm_read,
  output logic        o_avm_write,
  output logic [3:0]  o_avm_byteenable,
  output logic [31:0] o_avm_writedata,
  input  logic [31:0] i_avm_readdata,
  input  logic        i_avm_waitrequest
);

  localparam int            CW         = $clog2(POLL_TIMEOUT + 1);
  localparam logic [CW-1:0] POLL_LIMIT = CW'(POLL_TIMEOUT - 1);

  seq_state_t    r_state, w_state_nx;
  logic [31:0]   r_lba;
  logic [6:0]    r_k;
  logic [CW-1:0] r_poll_cnt;
  logic [1:0]    r_error;
  logic [31:0]   r_data;

  logic        w_start, w_write, w_acc_done;
  logic [7:0]  w_addr;
  logic [31:0] w_wdata, w_rdata;
  logic        w_accept, w_cnt_clr, w_k_clr, w_k_inc, w_err_load;
  logic [1:0]  w_err_code;
  logic        w_polling, w_poll_expired;

  assign w_polling      = (r_state == S_CHK) || (r_state == S_POLL);
  assign w_poll_expired = w_polling && (r_poll_cnt == POLL_LIMIT);

  sd_avm_single_access u_access (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_start           (w_start),
    .i_write           (w_write),
    .i_address         (w_addr),
    .i_writedata       (w_wdata),
    .o_done            (w_acc_done),
    .o_readdata        (w_rdata),
    .o_avm_chip_select (o_avm_chip_select),
    .o_avm_address     (o_avm_address),
    .o_avm_read        (o_avm_read),
    .o_avm_write       (o_avm_write),
    .o_avm_byteenable  (o_avm_byteenable),
    .o_avm_writedata   (o_avm_writedata),
    .i_avm_readdata    (i_avm_readdata),
    .i_avm_waitrequest (i_avm_waitrequest)
  );

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Next state; each step launches the following access in the cycle the current one completes.
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_write    = 1'b0;
    w_addr     = 8'd0;
    w_wdata    = 32'd0;
    w_accept   = 1'b0;
    w_cnt_clr  = 1'b0;
    w_k_clr    = 1'b0;
    w_k_inc    = 1'b0;
    w_err_load = 1'b0;
    w_err_code = ERR_OK;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_accept   = 1'b1;
          w_start    = 1'b1;
          w_addr     = ADDR_ASR;
          w_state_nx = S_CHK;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_CHK: begin
        if (!w_acc_done) begin
          w_state_nx = S_CHK;
        end else if (w_poll_expired) begin
          w_err_load = 1'b1;
          w_err_code = ERR_POLL_TIMEOUT;
          w_state_nx = S_DONE;
        end else if (!w_rdata[ASR_PRESENT] || !w_rdata[ASR_VALID]) begin
          w_err_load = 1'b1;
          w_err_code = ERR_NO_CARD;
          w_state_nx = S_DONE;
        end else if (w_rdata[ASR_BUSY]) begin
          w_start    = 1'b1;
          w_addr     = ADDR_ASR;
          w_state_nx = S_CHK;
        end else begin
          w_cnt_clr  = 1'b1;
          w_start    = 1'b1;
          w_write    = 1'b1;
          w_addr     = ADDR_CMD_ARG;
          w_wdata    = cmd_arg(r_lba, BYTE_ADDRESSING);
          w_state_nx = S_ARG;
        end
      end
      S_ARG: begin
        if (w_acc_done) begin
          w_start    = 1'b1;
          w_write    = 1'b1;
          w_addr     = ADDR_CMD;
          w_wdata    = CMD_READ_BLOCK;
          w_state_nx = S_CMD;
        end else begin
          w_state_nx = S_ARG;
        end
      end
      S_CMD: begin
        if (w_acc_done) begin
          w_start    = 1'b1;
          w_addr     = ADDR_ASR;
          w_state_nx = S_POLL;
        end else begin
          w_state_nx = S_CMD;
        end
      end
      S_POLL: begin
        if (!w_acc_done) begin
          w_state_nx = S_POLL;
        end else if (w_poll_expired) begin
          w_err_load = 1'b1;
          w_err_code = ERR_POLL_TIMEOUT;
          w_state_nx = S_DONE;
        end else if (w_rdata[ASR_BUSY]) begin
          w_start    = 1'b1;
          w_addr     = ADDR_ASR;
          w_state_nx = S_POLL;
        end else if (w_rdata[ASR_TIMEOUT] || w_rdata[ASR_CRC]) begin
          w_err_load = 1'b1;
          w_err_code = ERR_CORE;
          w_state_nx = S_DONE;
        end else begin
          w_k_clr    = 1'b1;
          w_start    = 1'b1;
          w_addr     = 8'd0;
          w_state_nx = S_BUF;
        end
      end
      S_BUF: begin
        if (w_acc_done) w_state_nx = S_OUT;
        else            w_state_nx = S_BUF;
      end
      S_OUT: begin
        if (!i_data_ready) begin
          w_state_nx = S_OUT;
        end else if (r_k == 7'd127) begin
          w_err_load = 1'b1;
          w_err_code = ERR_OK;
          w_state_nx = S_DONE;
        end else begin
          w_k_inc    = 1'b1;
          w_start    = 1'b1;
          w_addr     = {1'b0, r_k + 7'd1};
          w_state_nx = S_BUF;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Request context, word index, poll counter, status code and the captured sector word.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lba      <= 32'd0;
      r_k        <= 7'd0;
      r_poll_cnt <= '0;
      r_error    <= ERR_OK;
      r_data     <= 32'd0;
    end else begin
      if (w_accept) r_lba <= i_req_lba;
      else          r_lba <= r_lba;

      if (w_k_clr)      r_k <= 7'd0;
      else if (w_k_inc) r_k <= r_k + 7'd1;
      else              r_k <= r_k;

      // Saturates at the limit so a stalled final access still reports the timeout.
      if (w_accept || w_cnt_clr)                r_poll_cnt <= '0;
      else if (w_polling && !w_poll_expired)    r_poll_cnt <= r_poll_cnt + CW'(1);
      else                                      r_poll_cnt <= r_poll_cnt;

      if (w_accept)        r_error <= ERR_OK;
      else if (w_err_load) r_error <= w_err_code;
      else                 r_error <= r_error;

      if (r_state == S_BUF && w_acc_done) r_data <= w_rdata;
      else                                r_data <= r_data;
    end
  end

  assign o_req_ready  = (r_state == S_IDLE) & ~i_reset;
  assign o_data       = r_data;
  assign o_data_valid = (r_state == S_OUT);
  assign o_data_last  = (r_state == S_OUT) && (r_k == 7'd127);
  assign o_done       = (r_state == S_DONE);
  assign o_error      = r_error;

endmodule

// File: tb/tb_sd_sector_read_sequencer.sv
// Directed and randomized bench for sd_sector_read_sequencer with a behavioural SD core
// model (status register, sector buffer, write log) and a stream/done monitor.
module tb_sd_sector_read_sequencer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic [31:0] i_req_lba;
  logic        o_req_ready;
  logic [31:0] o_data;
  logic        o_data_valid, o_data_last;
  logic        i_data_ready = 1'b1;
  logic        o_done;
  logic [1:0]  o_error;
  logic        o_avm_chip_select;
  logic [7:0]  o_avm_address;
  logic        o_avm_read, o_avm_write;
  logic [3:0]  o_avm_byteenable;
  logic [31:0] o_avm_writedata;
  logic [31:0] i_avm_readdata;
  logic        i_avm_waitrequest = 1'b0;

  sd_sector_read_sequencer #(.POLL_TIMEOUT(100), .BYTE_ADDRESSING(1'b1)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_lba(i_req_lba), .o_req_ready(o_req_ready),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_data_last(o_data_last),
    .i_data_ready(i_data_ready), .o_done(o_done), .o_error(o_error),
    .o_avm_chip_select(o_avm_chip_select), .o_avm_address(o_avm_address),
    .o_avm_read(o_avm_read), .o_avm_write(o_avm_write),
    .o_avm_byteenable(o_avm_byteenable), .o_avm_writedata(o_avm_writedata),
    .i_avm_readdata(i_avm_readdata), .i_avm_waitrequest(i_avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Core model configuration (written by the stimulus only).
  logic [31:0] buf_mem [0:127];
  logic cfg_present = 1'b1, cfg_valid = 1'b1, cfg_stuck = 1'b0, cfg_tout = 1'b0, cfg_crc = 1'b0;
  int   cfg_chk_busy = 0, cfg_poll_busy = 0;
  logic wait_mode = 1'b0, rdy_mode = 1'b0;

  // Observations (written by the monitor only).
  int          cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [1:0]  done_err = 2'd0;
  logic        cmd_seen = 1'b0;
  int          chk_reads = 0, poll_reads = 0, buf_reads = 0, n_wr = 0;
  logic [7:0]  wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  int          n_words = 0, n_last = 0, last_pos = -1, first_cyc = 0, last_cyc = 0;
  logic [31:0] got_data [0:127];
  int          proto_err = 0;
  logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [7:0]  prev_addr = 8'd0;
  logic [31:0] prev_wdata = 32'd0;

  int n_cmp = 0, n_bad = 0;

  logic [31:0] asr;
  always_comb begin
    asr = 32'd0;
    asr[0] = cfg_valid;
    asr[1] = cfg_present;
    if (!cmd_seen) begin
      asr[2] = (chk_reads < cfg_chk_busy);
    end else begin
      asr[2] = cfg_stuck || (poll_reads < cfg_poll_busy);
      asr[4] = cfg_tout & ~asr[2];
      asr[5] = cfg_crc & ~asr[2];
    end
  end

  always_comb begin
    if (o_avm_address < 8'd128) i_avm_readdata = buf_mem[o_avm_address[6:0]];
    else if (o_avm_address == 8'd141) i_avm_readdata = asr;
    else i_avm_readdata = 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    i_avm_waitrequest = wait_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
    i_data_ready      = rdy_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: bus completions, stream handshakes, done pulses and stall stability.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_req_valid && o_req_ready) begin
      acc_cnt <= acc_cnt + 1; acc_cyc <= cyc; cmd_seen <= 1'b0;
      chk_reads <= 0; poll_reads <= 0; buf_reads <= 0; n_wr <= 0;
      n_words <= 0; n_last <= 0; last_pos <= -1;
    end else begin
      if ((o_avm_read || o_avm_write) && !i_avm_waitrequest) begin
        if (o_avm_write) begin
          if (n_wr < 8) begin
            wr_addr[n_wr] <= o_avm_address;
            wr_data[n_wr] <= o_avm_writedata;
          end
          n_wr <= n_wr + 1;
          if (o_avm_address == 8'd140) cmd_seen <= 1'b1;
        end else if (o_avm_address == 8'd141) begin
          if (cmd_seen) poll_reads <= poll_reads + 1;
          else          chk_reads  <= chk_reads + 1;
        end else if (o_avm_address < 8'd128) begin
          buf_reads <= buf_reads + 1;
        end
      end
      if (o_data_valid && i_data_ready) begin
        if (n_words < 128) got_data[n_words] <= o_data;
        if (o_data_last) begin n_last <= n_last + 1; last_pos <= n_words; end
        if (n_words == 0) first_cyc <= cyc;
        last_cyc <= cyc;
        n_words <= n_words + 1;
      end
    end
    if (o_done) begin done_cnt <= done_cnt + 1; done_err <= o_error; done_cyc <= cyc; end
    if (!i_reset) begin
      if (prev_stall && (o_avm_address != prev_addr || o_avm_read != prev_rd ||
                         o_avm_write != prev_wr || o_avm_writedata != prev_wdata))
        proto_err <= proto_err + 1;
      if ((o_avm_read || o_avm_write) &&
          (o_avm_byteenable != 4'hF || !o_avm_chip_select || (o_avm_read && o_avm_write)))
        proto_err <= proto_err + 1;
    end
    prev_stall <= (o_avm_read || o_avm_write) && i_avm_waitrequest && !i_reset;
    prev_addr  <= o_avm_address;
    prev_rd    <= o_avm_read;
    prev_wr    <= o_avm_write;
    prev_wdata <= o_avm_writedata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_buf();
    for (int i = 0; i < 128; i++) buf_mem[i] = $urandom;
  endtask

  task automatic set_cfg(input logic present, input int chk_busy, input int poll_busy,
                         input logic stuck, input logic tout, input logic crc);
    cfg_present = present; cfg_valid = 1'b1; cfg_chk_busy = chk_busy;
    cfg_poll_busy = poll_busy; cfg_stuck = stuck; cfg_tout = tout; cfg_crc = crc;
  endtask

  task automatic issue(input string tag, input logic [31:0] lba);
    int snap;
    snap = acc_cnt;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_lba   = lba;
    for (int t = 0; t < 20 && acc_cnt == snap; t++) @(negedge clk);
    i_req_valid = 1'b0;
    check({tag, "_accepted"}, 64'(acc_cnt - snap), 64'(1));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int snap;
    snap = done_cnt;
    for (int t = 0; t < budget && done_cnt == snap; t++) @(negedge clk);
    check({tag, "_done_seen"}, 64'(done_cnt - snap), 64'(1));
  endtask

  // Reference: a good read writes CMD_ARG = lba*512 then CMD = 17 and streams the buffer in order.
  task automatic check_success(input string tag, input logic [31:0] lba);
    int mism;
    logic [31:0] exp_arg;
    exp_arg = lba * 32'd512;
    mism = 0;
    for (int i = 0; i < 128; i++) if (got_data[i] !== buf_mem[i]) mism++;
    check({tag, "_error"},     64'(done_err), 64'(0));
    check({tag, "_n_writes"},  64'(n_wr), 64'(2));
    check({tag, "_wr0"},       {24'd0, wr_addr[0], wr_data[0]}, {24'd0, 8'd139, exp_arg});
    check({tag, "_wr1"},       {24'd0, wr_addr[1], wr_data[1]}, {24'd0, 8'd140, 32'd17});
    check({tag, "_n_words"},   64'(n_words), 64'(128));
    check({tag, "_data_mism"}, 64'(mism), 64'(0));
    check({tag, "_last"},      {32'(n_last), 32'(last_pos)}, {32'd1, 32'd127});
    check({tag, "_buf_reads"}, 64'(buf_reads), 64'(128));
    check({tag, "_protocol"},  64'(proto_err), 64'(0));
  endtask

  initial begin
    logic [31:0] lba;
    int snap;
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_lba = 32'd0;
    fill_buf();
    repeat (3) @(negedge clk);
    check("rst_outputs", {o_req_ready, o_data_valid, o_done, o_avm_chip_select, o_avm_read,
                          o_avm_write, o_error, o_data}, 64'd0);
    i_reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {o_req_ready, o_error}, {1'b1, 2'd0});

    // Nominal read, busy for 20 polls, zero stalls: also checks 2-cycle word throughput.
    set_cfg(1'b1, 0, 20, 1'b0, 1'b0, 1'b0);
    issue("lba5", 32'd5);
    wait_done("lba5", 2000);
    check_success("lba5", 32'd5);
    check("lba5_poll_reads", 64'(poll_reads), 64'(21));
    check("lba5_throughput", 64'(last_cyc - first_cyc <= 254), 64'(1));

    // No card: one status read, no writes.
    set_cfg(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    issue("nocard", 32'd9);
    wait_done("nocard", 200);
    check("nocard_error", 64'(done_err), 64'(1));
    check("nocard_writes", 64'(n_wr), 64'(0));
    check("nocard_asr_reads", 64'(chk_reads + poll_reads), 64'(1));

    // Core timeout flag, then CRC flag after the command: no buffer reads.
    set_cfg(1'b1, 0, 2, 1'b0, 1'b1, 1'b0);
    issue("tout", 32'd3);
    wait_done("tout", 200);
    check("tout_error", 64'(done_err), 64'(2));
    check("tout_buf_reads", 64'(buf_reads), 64'(0));
    check("tout_writes", 64'(n_wr), 64'(2));
    set_cfg(1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
    issue("crc", 32'd4);
    wait_done("crc", 200);
    check("crc_error", 64'(done_err), 64'(2));
    check("crc_buf_reads", 64'(buf_reads), 64'(0));

    // Busy stuck: poll timeout near 100 cycles, status held, next request succeeds.
    set_cfg(1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
    issue("stuck", 32'd7);
    wait_done("stuck", 500);
    check("stuck_error", 64'(done_err), 64'(3));
    check("stuck_latency", 64'(done_cyc - acc_cyc >= 100 && done_cyc - acc_cyc <= 110), 64'(1));
    repeat (3) @(negedge clk);
    check("stuck_error_held", {o_req_ready, o_error}, {1'b1, 2'd3});
    set_cfg(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    fill_buf();
    issue("after_stuck", 32'd11);
    wait_done("after_stuck", 2000);
    check_success("after_stuck", 32'd11);

    // Randomized: 50% waitrequest, random sink ready, random lba/buffer/busy counts.
    for (int r = 0; r < 3; r++) begin
      wait_mode = 1'b1; rdy_mode = 1'b1;
      fill_buf();
      lba = $urandom;
      set_cfg(1'b1, $urandom_range(0, 3), $urandom_range(0, 5), 1'b0, 1'b0, 1'b0);
      issue($sformatf("rand%0d", r), lba);
      wait_done($sformatf("rand%0d", r), 6000);
      check_success($sformatf("rand%0d", r), lba);
    end
    wait_mode = 1'b0; rdy_mode = 1'b0;

    // Reset while word 60 is presented: everything drops at once, no done pulse.
    fill_buf();
    set_cfg(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    issue("abort", 32'd2);
    for (int t = 0; t < 2000 && !(n_words == 60 && o_data_valid); t++) @(negedge clk);
    check("abort_at_word60", {32'(n_words), 32'(o_data_valid)}, {32'd60, 32'd1});
    snap = done_cnt;
    #2 i_reset = 1'b1;
    #1 check("abort_outputs", {o_data_valid, o_data_last, o_done, o_req_ready, o_avm_chip_select,
                               o_avm_read, o_avm_write, o_error, o_data}, 64'd0);
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - snap), 64'(0));
    check("abort_ready", 64'(o_req_ready), 64'(1));
    fill_buf();
    issue("fresh", 32'h0000_1234);
    wait_done("fresh", 2000);
    check_success("fresh", 32'h0000_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
